// File: rtl/maple_in_if.sv
`default_nettype none
// ============================================================================
// Module   : maple_in_if
// Function : Pin, FIFO-write and status bundle between maple_in and its
//            bus controller.
// Revision : 1.0
// ============================================================================
interface maple_in_if;
    logic       pin1;
    logic       pin5;
    logic       enable;
    logic       fifo_full;
    logic       err_clear;
    logic [7:0] fifo_data;
    logic       data_produce;
    logic       start_seen;
    logic       end_seen;
    logic       active;
    logic       err_framing;
    logic       err_overflow;

    // Bus controller side: arms the receiver, owns the FIFO and the pads.
    modport master (
        output pin1, pin5, enable, fifo_full, err_clear,
        input  fifo_data, data_produce, start_seen, end_seen,
        input  active, err_framing, err_overflow
    );

    modport slave (
        input  pin1, pin5, enable, fifo_full, err_clear,
        output fifo_data, data_produce, start_seen, end_seen,
        output active, err_framing, err_overflow
    );
endinterface
`default_nettype wire

// File: rtl/maple_in.sv
`default_nettype none
// ============================================================================
// Module   : maple_in
// Function : Maple bus receiver - start/data/end pattern decode into a byte FIFO.
// Options  : define MAPLE_IN_TIMEOUT_EN to abort frames on a stalled bus.
// Revision : 1.0
// ============================================================================
module maple_in #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic  clk,
    input  wire logic  rst,
    maple_in_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA_A = 3'd2;
    localparam logic [2:0] S_DATA_B = 3'd3;
    localparam logic [2:0] S_END    = 3'd4;

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("maple_in: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync1_q, sync1_d, sync5_q, sync5_d;
    logic       prev1_q, prev5_q;
    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] fifo_data_q, fifo_data_d;
    logic       data_produce_q, data_produce_d;
    logic       start_seen_q, start_seen_d;
    logic       end_seen_q, end_seen_d;
    logic       active_q, active_d;
    logic       err_framing_q, err_framing_d;
    logic       err_overflow_q, err_overflow_d;

    logic p1, p5, fall1, rise1, fall5, rise5;
    logic frame_err, ovf_err, bit_valid, bit_val, to_hit;

    assign p1    = sync1_q[SYNC_STAGES-1];
    assign p5    = sync5_q[SYNC_STAGES-1];
    assign fall1 =  prev1_q & ~p1;
    assign rise1 = ~prev1_q &  p1;
    assign fall5 =  prev5_q & ~p5;
    assign rise5 = ~prev5_q &  p5;

`ifdef MAPLE_IN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Any pin edge counts as bus activity and restarts the stall window.
    always_comb begin
        to_hit   = 1'b0;
        to_cnt_d = '0;
        if (state_q != S_IDLE && !(fall1 | rise1 | fall5 | rise5)) begin
            to_cnt_d = to_cnt_q + 1'b1;
            to_hit   = (to_cnt_d == TO_W'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        sync1_d        = {sync1_q[SYNC_STAGES-2:0], bus.pin1};
        sync5_d        = {sync5_q[SYNC_STAGES-2:0], bus.pin5};
        state_d        = state_q;
        cnt_d          = cnt_q;
        bitcnt_d       = bitcnt_q;
        shift_d        = shift_q;
        fifo_data_d    = fifo_data_q;
        active_d       = active_q;
        data_produce_d = 1'b0;
        start_seen_d   = 1'b0;
        end_seen_d     = 1'b0;
        frame_err      = 1'b0;
        ovf_err        = 1'b0;
        bit_valid      = 1'b0;
        bit_val        = 1'b0;

        if (state_q != S_IDLE && ((fall1 && fall5) || to_hit)) begin
            frame_err = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fall1 && p5) begin
                        state_d = S_START;
                        cnt_d   = 3'd0;
                    end
                end
                S_START: begin
                    if (fall5 && cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
                    if (rise1) begin
                        if (cnt_q == 3'd4) begin
                            start_seen_d = 1'b1;
                            active_d     = 1'b1;
                            bitcnt_d     = 3'd0;
                            state_d      = S_DATA_A;
                        end else begin
                            frame_err = 1'b1;
                        end
                    end
                end
                S_DATA_A: begin
                    if (fall1) begin
                        bit_valid = 1'b1;
                        bit_val   = p5;
                        state_d   = S_DATA_B;
                    end else if (fall5 && p1) begin
                        // pin5 dropping while pin1 idles high opens the end pattern
                        if (bitcnt_q == 3'd0) begin
                            state_d = S_END;
                            cnt_d   = 3'd0;
                        end else begin
                            frame_err = 1'b1;
                        end
                    end
                end
                S_DATA_B: begin
                    if (fall5) begin
                        bit_valid = 1'b1;
                        bit_val   = p1;
                        state_d   = S_DATA_A;
                    end else if (fall1) begin
                        frame_err = 1'b1;
                    end
                end
                S_END: begin
                    if (fall1 && cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
                    if (rise5 && p1) begin
                        if (cnt_q == 3'd2) begin
                            end_seen_d = 1'b1;
                            active_d   = 1'b0;
                            state_d    = S_IDLE;
                        end else begin
                            frame_err = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (bit_valid) begin
            shift_d  = {shift_q[6:0], bit_val};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                fifo_data_d = shift_d;
                if (bus.fifo_full) ovf_err        = 1'b1;
                else               data_produce_d = 1'b1;
            end
        end

        if (frame_err) begin
            state_d  = S_IDLE;
            active_d = 1'b0;
        end

        // Disarmed receiver: park in IDLE silently, leaving sticky errors alone.
        if (!bus.enable) begin
            state_d        = S_IDLE;
            active_d       = 1'b0;
            start_seen_d   = 1'b0;
            end_seen_d     = 1'b0;
            data_produce_d = 1'b0;
            frame_err      = 1'b0;
            ovf_err        = 1'b0;
        end

        err_framing_d  = (err_framing_q  & ~bus.err_clear) | frame_err;
        err_overflow_d = (err_overflow_q & ~bus.err_clear) | ovf_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q        <= '1;
            sync5_q        <= '1;
            prev1_q        <= 1'b1;
            prev5_q        <= 1'b1;
            state_q        <= S_IDLE;
            cnt_q          <= 3'd0;
            bitcnt_q       <= 3'd0;
            shift_q        <= 8'd0;
            fifo_data_q    <= 8'd0;
            data_produce_q <= 1'b0;
            start_seen_q   <= 1'b0;
            end_seen_q     <= 1'b0;
            active_q       <= 1'b0;
            err_framing_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync5_q        <= sync5_d;
            prev1_q        <= p1;
            prev5_q        <= p5;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bitcnt_q       <= bitcnt_d;
            shift_q        <= shift_d;
            fifo_data_q    <= fifo_data_d;
            data_produce_q <= data_produce_d;
            start_seen_q   <= start_seen_d;
            end_seen_q     <= end_seen_d;
            active_q       <= active_d;
            err_framing_q  <= err_framing_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign bus.fifo_data    = fifo_data_q;
    assign bus.data_produce = data_produce_q;
    assign bus.start_seen   = start_seen_q;
    assign bus.end_seen     = end_seen_q;
    assign bus.active       = active_q;
    assign bus.err_framing  = err_framing_q;
    assign bus.err_overflow = err_overflow_q;
endmodule
`default_nettype wire
